instmem_loader: RTL and testbench

- Writer-side counterpart to the instruction ROM: it fills instruction memory with a program before the CPU starts.
- Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles bytes into 32-bit words in the same big-endian byte order the fetch path reads: the byte at the lowest address is the MSB of the word.
- Issues single-cycle word writes starting at the reset-vector base address. While it is loading, the CPU is held off via `busy`.

---
 rtl/instmem_loader.sv | 153 +++++++++++++++
 tb/tb_instmem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instmem_loader.sv
// Byte-stream instruction memory loader: 16-bit big-endian word count, then big-endian data words
// written from BASE_ADDR upward. Optional trailing XOR checksum with INSTMEM_LOADER_CHECKSUM_EN.
module instmem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int          MAX_WORDS = 1024,
  parameter int          LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_WIDTH-1:0] word_cnt
);

  // Handshake: a byte moves only on a cycle where in_valid && in_ready; in_ready depends on state only.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [31:0]          word_q, word_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b1;
    done       = (state_q == S_DONE);
    err        = (state_q == S_ERR);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        busy = 1'b0;
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          byte_idx_d = '0;
          word_cnt_d = '0;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          len_d   = LEN_WIDTH'(in_data);
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          len_d = {len_q[LEN_WIDTH-9:0], in_data};
          if (len_d == '0) begin
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if ({{(32-LEN_WIDTH){1'b0}}, len_d} > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First byte received ends up in bits [31:24] after four shifts.
          word_d     = {word_q[23:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = BASE_ADDR + {{(30-LEN_WIDTH){1'b0}}, word_cnt_q, 2'b00};
        mem_wdata  = word_q;
        word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
        if (word_cnt_d == len_q) begin
`ifdef INSTMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_instmem_loader.sv
// Randomized bench for instmem_loader; reference model decodes the byte stream directly into
// expected (address, word) writes. Honours INSTMEM_LOADER_CHECKSUM_EN like the design.
module tb_instmem_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          MAXW = 1024;
  localparam int          LW   = 16;

  typedef logic [7:0] byte_q_t[$];

  logic          clk, rst_n, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, busy, done, err;
  logic [31:0]   mem_addr, mem_wdata;
  logic [LW-1:0] word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];
  logic        exp_done;
  logic [31:0] exp_cnt;

  logic [31:0] obs_addr_q[$];
  logic [31:0] obs_q[$];
  int          bus_viol;

  instmem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        obs_addr_q.push_back(mem_addr);
        obs_q.push_back(mem_wdata);
        if (mem_addr[1:0] != 2'b00 || mem_addr < BASE || mem_addr > BASE + 4 * (MAXW - 1))
          bus_viol++;
      end else if (mem_addr != 32'h0 || mem_wdata != 32'h0) begin
        bus_viol++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: decode the session stream straight from the framing rules.
  task automatic model(input byte_q_t b);
    int   len;
    logic [7:0] x;
    exp_addr_q.delete();
    exp_q.delete();
    len = int'({b[0], b[1]});
    x = 8'h00;
    exp_cnt = 0;
    if (len > MAXW) begin
      exp_done = 1'b0;
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_addr_q.push_back(BASE + 32'(4 * i));
        exp_q.push_back({b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
        x = x ^ b[2+4*i] ^ b[3+4*i] ^ b[4+4*i] ^ b[5+4*i];
      end
      exp_cnt = 32'(len);
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      exp_done = (b.size() > 2 + 4 * len) && (b[2+4*len] == x);
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic make_load(input int n, output byte_q_t b);
    logic [7:0] x;
    logic [7:0] v;
    b.delete();
    x = 8'h00;
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      v = 8'($urandom_range(0, 255));
      b.push_back(v);
      x = x ^ v;
    end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    b.push_back(x);
`endif
  endtask

  // Driver: optional idle gap (with stray start pulses), then hold the byte until accepted.
  task automatic send_byte(input logic [7:0] v, input int gap, input bit extra_start);
    int t;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = extra_start ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data = v;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("byte_accept_timeout", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_session(input string tag, input byte_q_t b, input int max_gap,
                             input bit extra_start);
    int t;
    model(b);
    obs_addr_q.delete();
    obs_q.delete();
    bus_viol = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'h1);
    foreach (b[i]) send_byte(b[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0, extra_start);
    t = 0;
    while (!(done || err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_end_timeout"}, 32'(done || err), 32'h1);
    check({tag, "_done_err"}, {30'h0, done, err}, {30'h0, exp_done, ~exp_done});
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    check({tag, "_word_cnt"}, 32'(word_cnt), exp_cnt);
    check({tag, "_n_writes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), obs_addr_q[i], exp_addr_q[i]);
        check($sformatf("%s_data%0d", tag, i), obs_q[i], exp_q[i]);
      end
    end
    check({tag, "_bus_rules"}, bus_viol, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    byte_q_t b;
    byte_q_t b2;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; bus_viol = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, mem_we, busy, done, err, 11'h0, word_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {in_ready, mem_we, busy, done, err, 11'h0, word_cnt}, 32'h0);
    check("idle_bus", mem_addr | mem_wdata, 32'h0);

    // Two-word directed load
    b = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    b.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h13);
`endif
    run_session("two_words", b, 0, 1'b0);
    if (obs_q.size() >= 2) begin
      check("two_words_w0", obs_q[0], 32'hDEADBEEF);
      check("two_words_a1", obs_addr_q[1], 32'hBFC00004);
      check("two_words_w1", obs_q[1], 32'h00000013);
    end

    // Zero length
    make_load(0, b);
    run_session("len_zero", b, 0, 1'b0);

    // Oversized lengths
    b = '{8'h04, 8'h01};
    run_session("len_1025", b, 0, 1'b0);
    b = '{8'hFF, 8'hFF};
    run_session("len_ffff", b, 2, 1'b0);

    // Gapless versus gapped with stray starts on identical data
    make_load(5, b);
    run_session("rand5_nogap", b, 0, 1'b0);
    run_session("rand5_gaps", b, 4, 1'b1);

    // Reset in the middle of a three-word load
    make_load(3, b2);
    obs_q.delete();
    obs_addr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(b2[i], 0, 1'b0);
    repeat (2) @(negedge clk);
    check("midrst_writes_before", obs_q.size(), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {in_ready, mem_we, busy, done, err, 11'h0, word_cnt}, 32'h0);
    check("midrst_bus", mem_addr | mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_session("midrst_reload", b2, 1, 1'b0);

    // Random lengths and the full-capacity boundary
    for (int k = 0; k < 4; k++) begin
      make_load($urandom_range(1, 9), b);
      run_session($sformatf("rand_%0d", k), b, 3, 1'b1);
    end
    make_load(MAXW, b);
    run_session("len_max", b, 0, 1'b0);

`ifdef INSTMEM_LOADER_CHECKSUM_EN
    b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_session("chk_good", b, 0, 1'b0);
    if (obs_q.size() >= 1) check("chk_good_w0", obs_q[0], 32'h12345678);
    check("chk_good_done", 32'(done), 32'h1);
    b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_session("chk_bad", b, 0, 1'b0);
    if (obs_q.size() >= 1) check("chk_bad_w0", obs_q[0], 32'h12345678);
    check("chk_bad_err", 32'(err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
